// File: rtl/lorentz_pkg.sv
`default_nettype none
//==============================================================================
// Module   : lorentz_pkg
// Brief    : State encodings and default Q32.32 constants for the Lorenz stepper.
// Revision : 1.0
//==============================================================================
package lorentz_pkg;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_m0   = 3'd1;
    localparam logic [2:0] c_st_m1   = 3'd2;
    localparam logic [2:0] c_st_m2   = 3'd3;
    localparam logic [2:0] c_st_m3   = 3'd4;
    localparam logic [2:0] c_st_upd  = 3'd5;
    localparam logic [2:0] c_st_out  = 3'd6;

    localparam logic [63:0] c_sigma_q32 = 64'h0000_000A_0000_0000;
    localparam logic [63:0] c_rho_q32   = 64'h0000_001C_0000_0000;
    localparam logic [63:0] c_beta_q32  = 64'h0000_0002_AAAA_AAAA;
    localparam logic [63:0] c_one_q32   = 64'h0000_0001_0000_0000;

endpackage
`default_nettype wire

// File: rtl/lorentz_fxmul.sv
`default_nettype none
//==============================================================================
// Module   : lorentz_fxmul
// Brief    : Combinational signed fixed-point multiply with overflow detect.
//            Build option LORENTZ_SAT_EN clamps overflowing products.
// Revision : 1.0
//==============================================================================
module lorentz_fxmul #(
    parameter int W    = 64,
    parameter int FRAC = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_p,
    output logic         o_ovf
);

    logic signed [2*W-1:0] w_full;
    logic signed [2*W-1:0] w_shift;
    logic        [W:0]     w_hi;

    assign w_full  = $signed(i_a) * $signed(i_b);
    assign w_shift = w_full >>> FRAC;
    // Kept result is valid only if everything above it is a copy of its sign bit
    assign w_hi    = w_shift[2*W-1:W-1];
    assign o_ovf   = !((&w_hi) || (~|w_hi));

`ifdef LORENTZ_SAT_EN
    assign o_p = !o_ovf ? w_shift[W-1:0] :
                 w_full[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    assign o_p = w_shift[W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/lorentz_stepper.sv
`default_nettype none
//==============================================================================
// Module   : lorentz_stepper
// Brief    : Fixed-point Euler integrator for the Lorenz system with one shared
//            multiplier and a valid/ready sample stream.
//            Build option LORENTZ_SAT_EN: clamp overflowing results (else wrap).
// Revision : 1.0
//==============================================================================
module lorentz_stepper
    import lorentz_pkg::*;
#(
    parameter int           W        = 64,
    parameter int           FRAC     = 32,
    parameter int           DT_SHIFT = 7,
    parameter logic [W-1:0] SIGMA    = W'(c_sigma_q32),
    parameter logic [W-1:0] RHO      = W'(c_rho_q32),
    parameter logic [W-1:0] BETA     = W'(c_beta_q32),
    parameter logic [W-1:0] X0       = W'(c_one_q32),
    parameter logic [W-1:0] Y0       = W'(c_one_q32),
    parameter logic [W-1:0] Z0       = W'(c_one_q32),
    parameter int           N_STEPS  = 0,
    parameter int           CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     x_next,
    output logic [W-1:0]     y_next,
    output logic [W-1:0]     z_next,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    // Returns {overflow, result} of a signed W-bit add or subtract
    function automatic logic [W:0] f_addsub(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
        logic [W:0]   s;
        logic         ov;
        logic [W-1:0] r;
        s  = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
        ov = s[W] ^ s[W-1];
        r  = s[W-1:0];
`ifdef LORENTZ_SAT_EN
        if (ov) r = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {ov, r};
    endfunction

    logic [2:0]       r_state;
    logic [W-1:0]     r_x, r_y, r_z;
    logic [W-1:0]     r_dx, r_dy, r_p, r_dz;
    logic             r_valid, r_done, r_ovf, r_stop_pend;
    logic [CNT_W-1:0] r_step_cnt;

    logic [W-1:0]     w_mul_a, w_mul_b, w_mul_p;
    logic             w_mul_ovf, w_step_ovf, w_last;
    logic [W:0]       w_ymx, w_rmz, w_dy, w_dz, w_xn, w_yn, w_zn;
    logic [W-1:0]     w_dx_dt, w_dy_dt, w_dz_dt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_ymx   = f_addsub(r_y, r_x, 1'b1);
    assign w_rmz   = f_addsub(RHO, r_z, 1'b1);
    assign w_dy    = f_addsub(w_mul_p, r_y, 1'b1);
    assign w_dz    = f_addsub(r_p, w_mul_p, 1'b1);
    assign w_dx_dt = $signed(r_dx) >>> DT_SHIFT;
    assign w_dy_dt = $signed(r_dy) >>> DT_SHIFT;
    assign w_dz_dt = $signed(r_dz) >>> DT_SHIFT;
    assign w_xn    = f_addsub(r_x, w_dx_dt, 1'b0);
    assign w_yn    = f_addsub(r_y, w_dy_dt, 1'b0);
    assign w_zn    = f_addsub(r_z, w_dz_dt, 1'b0);

    // Operand steering for the single shared multiplier
    always_comb begin
        w_mul_a    = r_x;
        w_mul_b    = r_y;
        w_step_ovf = 1'b0;
        case (r_state)
            c_st_m0: begin
                w_mul_a    = SIGMA;
                w_mul_b    = w_ymx[W-1:0];
                w_step_ovf = w_ymx[W] | w_mul_ovf;
            end
            c_st_m1: begin
                w_mul_b    = w_rmz[W-1:0];
                w_step_ovf = w_rmz[W] | w_mul_ovf | w_dy[W];
            end
            c_st_m2:  w_step_ovf = w_mul_ovf;
            c_st_m3: begin
                w_mul_a    = BETA;
                w_mul_b    = r_z;
                w_step_ovf = w_mul_ovf | w_dz[W];
            end
            c_st_upd: w_step_ovf = w_xn[W] | w_yn[W] | w_zn[W];
            default:  w_step_ovf = 1'b0;
        endcase
    end

    lorentz_fxmul #(.W(W), .FRAC(FRAC)) u_fxmul (
        .i_a   (w_mul_a),
        .i_b   (w_mul_b),
        .o_p   (w_mul_p),
        .o_ovf (w_mul_ovf)
    );

    assign w_cnt_inc = r_step_cnt + CNT_W'(1);
    assign w_last    = r_stop_pend || stop || ((N_STEPS != 0) && (w_cnt_inc == CNT_W'(N_STEPS)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_x         <= X0;
            r_y         <= Y0;
            r_z         <= Z0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_p         <= '0;
            r_dz        <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_stop_pend <= 1'b0;
            r_step_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (stop && (r_state != c_st_idle)) r_stop_pend <= 1'b1;
            if (w_step_ovf) r_ovf <= 1'b1;
            case (r_state)
                c_st_idle: if (start) begin
                    r_step_cnt  <= '0;
                    r_stop_pend <= 1'b0;
                    r_state     <= c_st_m0;
                end
                c_st_m0: begin
                    r_dx    <= w_mul_p;
                    r_state <= c_st_m1;
                end
                c_st_m1: begin
                    r_dy    <= w_dy[W-1:0];
                    r_state <= c_st_m2;
                end
                c_st_m2: begin
                    r_p     <= w_mul_p;
                    r_state <= c_st_m3;
                end
                c_st_m3: begin
                    r_dz    <= w_dz[W-1:0];
                    r_state <= c_st_upd;
                end
                c_st_upd: begin
                    r_x     <= w_xn[W-1:0];
                    r_y     <= w_yn[W-1:0];
                    r_z     <= w_zn[W-1:0];
                    r_valid <= 1'b1;
                    r_state <= c_st_out;
                end
                c_st_out: if (out_ready) begin
                    r_valid    <= 1'b0;
                    r_step_cnt <= w_cnt_inc;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end else begin
                        r_state <= c_st_m0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign out_valid = r_valid;
    assign x_next    = r_x;
    assign y_next    = r_y;
    assign z_next    = r_z;
    assign step_cnt  = r_step_cnt;
    assign busy      = (r_state != c_st_idle);
    assign done      = r_done;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lorentz_stepper.sv
`default_nettype none
//==============================================================================
// Module   : tb_lorentz_stepper
// Brief    : Randomized self-checking bench for lorentz_stepper against an
//            arbitrary-precision Euler reference model.
// Revision : 1.0
//==============================================================================
module tb_lorentz_stepper;

    localparam logic [63:0] c_sigma  = 64'h0000_000A_0000_0000;
    localparam logic [63:0] c_rho    = 64'h0000_001C_0000_0000;
    localparam logic [63:0] c_beta   = 64'h0000_0002_AAAA_AAAA;
    localparam logic [63:0] c_one    = 64'h0000_0001_0000_0000;
    localparam logic [63:0] c_big_x0 = 64'h7FFF_0000_0000_0000;
    localparam logic signed [127:0] c_qmax = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] c_qmin = -128'sh8000_0000_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, start = 1'b0, stop = 1'b0, out_ready = 1'b0, start_n = 1'b0;

    logic        out_valid, busy, done, overflow;
    logic [63:0] x_next, y_next, z_next;
    logic [31:0] step_cnt;
    logic        valid_n, busy_n, done_n, ovf_n;
    logic [63:0] x_n, y_n, z_n;
    logic [31:0] cnt_n;
    logic        valid_o, busy_o, done_o, ovf_o;
    logic [63:0] x_o, y_o, z_o;
    logic [31:0] cnt_o;

    lorentz_stepper dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .out_ready(out_ready),
        .out_valid(out_valid), .x_next(x_next), .y_next(y_next), .z_next(z_next),
        .step_cnt(step_cnt), .busy(busy), .done(done), .overflow(overflow)
    );

    lorentz_stepper #(.N_STEPS(4)) dut_n (
        .clk(clk), .reset(reset), .start(start_n), .stop(1'b0), .out_ready(1'b1),
        .out_valid(valid_n), .x_next(x_n), .y_next(y_n), .z_next(z_n),
        .step_cnt(cnt_n), .busy(busy_n), .done(done_n), .overflow(ovf_n)
    );

    lorentz_stepper #(.N_STEPS(1), .X0(c_big_x0)) dut_o (
        .clk(clk), .reset(reset), .start(start_n), .stop(1'b0), .out_ready(1'b1),
        .out_valid(valid_o), .x_next(x_o), .y_next(y_o), .z_next(z_o),
        .step_cnt(cnt_o), .busy(busy_o), .done(done_o), .overflow(ovf_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%h expected=0x%h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: exact wide result, then range-checked into Q32.32
    function automatic logic [64:0] q_fit(input logic signed [127:0] v);
        logic         o;
        logic [127:0] u;
        logic [63:0]  r;
        o = (v > c_qmax) || (v < c_qmin);
        u = v;
        r = u[63:0];
`ifdef LORENTZ_SAT_EN
        if (o) r = (v < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
        return {o, r};
    endfunction

    function automatic logic [64:0] q_mul(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ea, eb;
        ea = $signed(a);
        eb = $signed(b);
        return q_fit((ea * eb) >>> 32);
    endfunction

    function automatic logic [64:0] q_add(input logic [63:0] a, input logic [63:0] b, input bit neg);
        logic signed [127:0] ea, eb;
        ea = $signed(a);
        eb = $signed(b);
        return q_fit(neg ? (ea - eb) : (ea + eb));
    endfunction

    task automatic model_step(input logic [63:0] x, y, z,
                              output logic [63:0] nx, ny, nz, output bit ov);
        logic [64:0] t;
        logic [63:0] dx, dy, dz, r, p;
        ov = 0;
        t = q_add(y, x, 1);          ov |= t[64];  r  = t[63:0];
        t = q_mul(c_sigma, r);       ov |= t[64];  dx = t[63:0];
        t = q_add(c_rho, z, 1);      ov |= t[64];  r  = t[63:0];
        t = q_mul(x, r);             ov |= t[64];  r  = t[63:0];
        t = q_add(r, y, 1);          ov |= t[64];  dy = t[63:0];
        t = q_mul(x, y);             ov |= t[64];  p  = t[63:0];
        t = q_mul(c_beta, z);        ov |= t[64];  r  = t[63:0];
        t = q_add(p, r, 1);          ov |= t[64];  dz = t[63:0];
        t = q_add(x, 64'($signed(dx) >>> 7), 0);  ov |= t[64];  nx = t[63:0];
        t = q_add(y, 64'($signed(dy) >>> 7), 0);  ov |= t[64];  ny = t[63:0];
        t = q_add(z, 64'($signed(dz) >>> 7), 0);  ov |= t[64];  nz = t[63:0];
    endtask

    logic [63:0] mx, my, mz, ex, ey, ez;
    bit          mov, eov;
    int          mcnt;

    task automatic model_reset();
        mx = c_one; my = c_one; mz = c_one; mov = 0; mcnt = 0;
    endtask

    task automatic model_arm();
        bit s_ov;
        model_step(mx, my, mz, ex, ey, ez, s_ov);
        eov = mov | s_ov;
    endtask

    task automatic model_accept();
        mx = ex; my = ey; mz = ez; mov = eov; mcnt++;
        model_arm();
    endtask

    // Consume samples; in stop mode raise stop (and a stray start) in M2 of the last sample
    task automatic serve(input int n_hs, input bit rnd, input int stall, input bit do_stop);
        int  since, hs, stall_left;
        bit  fin;
        hs = 0; since = 0; stall_left = stall; fin = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            stop = 1'b0;
            start = 1'b0;
            since++;
            if (do_stop && done) begin
                check_val("done_latency", 64'(since), 64'd1);
                fin = 1;
            end else if (done) begin
                check_val("done_spurious", {63'd0, done}, 64'd0);
            end
            if (out_valid) begin
                check_val("x", x_next, ex);
                check_val("y", y_next, ey);
                check_val("z", z_next, ez);
                check_val("step_cnt", {32'd0, step_cnt}, 64'(mcnt));
                check_val("overflow", {63'd0, overflow}, {63'd0, eov});
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_ready) begin
                    hs++;
                    if (!rnd && stall == 0 && hs >= 2) check_val("period", 64'(since), 64'd6);
                    since = 0;
                    model_accept();
                    if (!do_stop && hs == n_hs) fin = 1;
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (do_stop && hs == n_hs - 1 && since == 3) begin
                stop  = 1'b1;
                start = 1'b1;
            end
        end
        if (!fin) check_val("serve_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int          n, hs_n;
        bit          seen, oov;
        logic [63:0] ox, oy, oz;

        repeat (3) @(negedge clk);
        check_val("rst_x", x_next, c_one);
        check_val("rst_y", y_next, c_one);
        check_val("rst_z", z_next, c_one);
        check_val("rst_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_cnt", {32'd0, step_cnt}, 64'd0);
        check_val("rst_ovf", {63'd0, overflow}, 64'd0);
        reset = 1'b0;
        model_reset();

        // First sample latency and known values
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        model_arm();
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("latency", 64'(n), 64'd5);
        check_val("first_x", x_next, 64'h0000_0001_0000_0000);
        check_val("first_y", y_next, 64'h0000_0001_3400_0000);
        check_val("first_z", z_next, 64'h0000_0000_FCAA_AAAA);

        serve(3, 0, 0, 0);
        serve(30, 1, 20, 0);
        serve(3, 1, 0, 1);
        check_val("stop_busy", {63'd0, busy}, 64'd0);
        check_val("stop_cnt", {32'd0, step_cnt}, 64'(mcnt));
        repeat (3) begin
            @(negedge clk);
            check_val("idle_busy", {63'd0, busy}, 64'd0);
            check_val("idle_done", {63'd0, done}, 64'd0);
        end

        // Reset while in UPD aborts the run without a done pulse
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_val("abort_x", x_next, c_one);
        check_val("abort_z", z_next, c_one);
        check_val("abort_valid", {63'd0, out_valid}, 64'd0);
        check_val("abort_cnt", {32'd0, step_cnt}, 64'd0);
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        check_val("abort_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        check_val("abort_done2", {63'd0, done}, 64'd0);

        model_reset();
        @(negedge clk); start = 1'b1;
        model_arm();
        serve(2, 1, 0, 0);

        // Step budget and overflow instances
        @(negedge clk); start_n = 1'b1;
        @(negedge clk); start_n = 1'b0;
        model_step(c_big_x0, c_one, c_one, ox, oy, oz, oov);
        hs_n = 0; seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (valid_n) hs_n++;
            if (valid_o) begin
                check_val("ovf_x", x_o, ox);
                check_val("ovf_y", y_o, oy);
                check_val("ovf_z", z_o, oz);
                check_val("ovf_flag", {63'd0, ovf_o}, 64'd1);
            end
            if (done_n) begin
                seen = 1;
                check_val("budget_cnt", {32'd0, cnt_n}, 64'd4);
                check_val("budget_busy", {63'd0, busy_n}, 64'd0);
            end
        end
        check_val("budget_hs", 64'(hs_n), 64'd4);
        check_val("budget_done", {63'd0, seen}, 64'd1);
        check_val("budget_ovf", {63'd0, ovf_n}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
